// File: rtl/qbert_rom_loader_if.sv
// -----------------------------------------------------------------------------
// qbert_rom_loader_if
//
// Bundles the HPS download stream (ioctl_*) and the ROM write / board control
// outputs of the Q*bert ROM loader into one interface.
//
// Signals:
//   ioctl_download  download active flag from hps_io
//   ioctl_wr        single-cycle byte strobe
//   ioctl_addr      25-bit byte address of the image
//   ioctl_dout      byte data
//   ioctl_index     download index (only the ROM index is acted upon)
//   ioctl_wait      stall request back to hps_io
//   rom_addr        region-relative write address
//   rom_data        write data
//   main_we         main CPU program region write strobe
//   gfx_we          graphics region write strobe
//   snd_we          sound CPU region write strobe
//   board_reset     reset to both boards
//   rom_ready       a complete image is loaded
//   load_error      sticky error from the last download
//
// Modports:
//   master  the download source side (hps_io / surrounding emu)
//   slave   the loader itself
// -----------------------------------------------------------------------------
interface qbert_rom_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        main_we;
  logic        gfx_we;
  logic        snd_we;
  logic        board_reset;
  logic        rom_ready;
  logic        load_error;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  ioctl_wait, rom_addr, rom_data, main_we, gfx_we, snd_we,
           board_reset, rom_ready, load_error
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output ioctl_wait, rom_addr, rom_data, main_we, gfx_we, snd_we,
           board_reset, rom_ready, load_error
  );
endinterface

// File: rtl/qbert_rom_loader.sv
// -----------------------------------------------------------------------------
// qbert_rom_loader
//
// Sequences the HPS ROM download stream into the core's three ROM regions
// (main CPU program, graphics, sound CPU), owns the ioctl_wait handshake and
// keeps both boards in reset while a download is running and for a hold
// period afterwards (and after a system reset).
//
// Ports:
//   clk_sys  system clock, the only clock
//   reset    synchronous, active-high
//   bus      qbert_rom_loader_if.slave: ioctl_* stream in, ROM write strobes,
//            region-relative address/data, board_reset, rom_ready, load_error
// -----------------------------------------------------------------------------
module qbert_rom_loader #(
  parameter logic [7:0]  ROM_INDEX   = 8'd1,
  parameter logic [24:0] MAIN_END    = 25'h0A000,
  parameter logic [24:0] GFX_END     = 25'h12000,
  parameter logic [24:0] SND_END     = 25'h13000,
  parameter int          WR_CYCLES   = 4,
  parameter int          HOLD_CYCLES = 1024
) (
  input  logic               clk_sys,
  input  logic               reset,
  qbert_rom_loader_if.slave  bus
);

  localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [3:0]        WR_LAST   = 4'(WR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_HOLD,
    S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [24:0]       byte_cnt_q, byte_cnt_d;
  logic [16:0]       rom_addr_q, rom_addr_d;
  logic [7:0]        rom_data_q, rom_data_d;
  logic              main_we_q, main_we_d;
  logic              gfx_we_q, gfx_we_d;
  logic              snd_we_q, snd_we_d;
  logic              wait_q, wait_d;
  logic              pend_q, pend_d;
  logic              dl_q;

  // Survive system reset so an OSD reset keeps a loaded image valid.
  logic              rom_ready_q  = 1'b0;
  logic              load_error_q = 1'b0;
  logic              rom_ready_d, load_error_d;

  logic              dl, dl_rise, dl_fall;
  logic              start, accept, finish, in_range;

  // Only downloads carrying the ROM index are of interest.
  assign dl      = bus.ioctl_download && (bus.ioctl_index == ROM_INDEX);
  assign dl_rise = dl && !dl_q;
  assign dl_fall = !dl && dl_q;

  // State and datapath registers. dl_q keeps tracking through reset so a
  // download that is still flagged after reset does not look like a new one.
  always_ff @(posedge clk_sys) begin
    dl_q <= dl;
    if (reset) begin
      state_q    <= S_HOLD;
      hold_q     <= HOLD_INIT;
      wcnt_q     <= '0;
      byte_cnt_q <= '0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      main_we_q  <= 1'b0;
      gfx_we_q   <= 1'b0;
      snd_we_q   <= 1'b0;
      wait_q     <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      wcnt_q     <= wcnt_d;
      byte_cnt_q <= byte_cnt_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
      main_we_q  <= main_we_d;
      gfx_we_q   <= gfx_we_d;
      snd_we_q   <= snd_we_d;
      wait_q     <= wait_d;
      pend_q     <= pend_d;
    end
  end

  // Status flags are frozen while reset is asserted rather than cleared.
  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      rom_ready_q  <= rom_ready_d;
      load_error_q <= load_error_d;
    end
  end

  // Next-state logic. The case statement only raises start/accept/finish
  // events; the shared actions for those events follow it so that a byte
  // arriving together with the download's rising edge is taken in one go.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    wcnt_d       = wcnt_q;
    byte_cnt_d   = byte_cnt_q;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;
    main_we_d    = 1'b0;
    gfx_we_d     = 1'b0;
    snd_we_d     = 1'b0;
    wait_d       = wait_q;
    pend_d       = pend_q;
    rom_ready_d  = rom_ready_q;
    load_error_d = load_error_q;
    start        = 1'b0;
    accept       = 1'b0;
    finish       = 1'b0;
    in_range     = 1'b0;

    case (state_q)
      S_HOLD: begin
        // The decremented count reaching zero ends the hold period.
        if (hold_q <= HOLD_ONE) begin
          hold_d  = '0;
          state_d = S_RUN;
        end else begin
          hold_d = hold_q - HOLD_ONE;
        end
        if (dl_rise) start = 1'b1;
      end

      S_IDLE, S_RUN: begin
        if (dl_rise) start = 1'b1;
      end

      S_LOAD: begin
        if (!dl) begin
          finish = 1'b1;
        end else if (bus.ioctl_wr) begin
          accept = 1'b1;
        end
      end

      S_WRITE: begin
        // A byte pushed while we are stalling is lost; flag it.
        if (bus.ioctl_wr && wait_q) load_error_d = 1'b1;
        if (dl_fall) pend_d = 1'b1;
        if (wcnt_q >= WR_LAST) begin
          wait_d = 1'b0;
          pend_d = 1'b0;
          if (pend_q || !dl) begin
            finish = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end

      default: state_d = S_HOLD;
    endcase

    if (start) begin
      state_d      = S_LOAD;
      byte_cnt_d   = '0;
      load_error_d = 1'b0;
      rom_ready_d  = 1'b0;
      if (bus.ioctl_wr) accept = 1'b1;
    end

    if (accept) begin
      state_d = S_WRITE;
      wait_d  = 1'b1;
      wcnt_d  = '0;
      pend_d  = 1'b0;
      if (bus.ioctl_addr < MAIN_END) begin
        main_we_d  = 1'b1;
        rom_addr_d = 17'(bus.ioctl_addr);
        rom_data_d = bus.ioctl_dout;
      end else if (bus.ioctl_addr < GFX_END) begin
        gfx_we_d   = 1'b1;
        rom_addr_d = 17'(bus.ioctl_addr - MAIN_END);
        rom_data_d = bus.ioctl_dout;
      end else if (bus.ioctl_addr < SND_END) begin
        snd_we_d   = 1'b1;
        rom_addr_d = 17'(bus.ioctl_addr - GFX_END);
        rom_data_d = bus.ioctl_dout;
      end else begin
        load_error_d = 1'b1;
      end
      in_range = main_we_d || gfx_we_d || snd_we_d;
      // Saturating count, based on byte_cnt_d so a same-cycle start counts from 0.
      if (in_range && (byte_cnt_d != '1)) byte_cnt_d = byte_cnt_d + 25'd1;
    end

    if (finish) begin
      state_d = S_HOLD;
      hold_d  = HOLD_INIT;
      wait_d  = 1'b0;
      if ((byte_cnt_q == SND_END) && !load_error_d) begin
        rom_ready_d = 1'b1;
      end else begin
        rom_ready_d  = 1'b0;
        load_error_d = 1'b1;
      end
    end
  end

  assign bus.ioctl_wait  = wait_q;
  assign bus.rom_addr    = rom_addr_q;
  assign bus.rom_data    = rom_data_q;
  assign bus.main_we     = main_we_q;
  assign bus.gfx_we      = gfx_we_q;
  assign bus.snd_we      = snd_we_q;
  assign bus.rom_ready   = rom_ready_q;
  assign bus.load_error  = load_error_q;
  // Boards only run once the hold period is over and a good image is present.
  assign bus.board_reset = (state_q != S_RUN) || !rom_ready_q;

endmodule

// File: tb/tb_qbert_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_qbert_rom_loader
//
// Self-checking bench for qbert_rom_loader. Region sizes are scaled down so
// several complete images fit in a short run; write slot and hold lengths use
// the real values. Expected strobes, relative addresses and final status are
// derived from the region map with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_qbert_rom_loader;

  localparam logic [24:0] MAIN_END    = 25'h00200;
  localparam logic [24:0] GFX_END     = 25'h00380;
  localparam logic [24:0] SND_END     = 25'h00400;
  localparam int          WR_CYCLES   = 4;
  localparam int          HOLD_CYCLES = 1024;

  logic clk = 1'b0;
  logic reset;

  qbert_rom_loader_if bus ();

  qbert_rom_loader #(
    .ROM_INDEX   (8'd1),
    .MAIN_END    (MAIN_END),
    .GFX_END     (GFX_END),
    .SND_END     (SND_END),
    .WR_CYCLES   (WR_CYCLES),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk_sys (clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int         assertCount = 0;
  int         failCount   = 0;
  logic [2:0] expWe       = 3'b000;
  int         mainSeen, gfxSeen, sndSeen;
  int         modelBytes;
  bit         modelErr;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference region map: one-hot {main,gfx,snd}, zero when out of range.
  function automatic logic [2:0] modelRegion(input logic [24:0] a);
    if (a < MAIN_END)     return 3'b100;
    else if (a < GFX_END) return 3'b010;
    else if (a < SND_END) return 3'b001;
    else                  return 3'b000;
  endfunction

  function automatic logic [16:0] modelRel(input logic [24:0] a);
    logic [24:0] r;
    if (a < MAIN_END)     r = a;
    else if (a < GFX_END) r = a - MAIN_END;
    else                  r = a - GFX_END;
    return r[16:0];
  endfunction

  // One clock; outputs are sampled 1 time unit after the rising edge and the
  // strobe vector is compared against what the model expects every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    checkOutput("weStrobe", {29'd0, bus.main_we, bus.gfx_we, bus.snd_we}, {29'd0, expWe});
    if (bus.main_we) mainSeen++;
    if (bus.gfx_we)  gfxSeen++;
    if (bus.snd_we)  sndSeen++;
  endtask

  task automatic waitReady();
    int guard = 0;
    while (bus.ioctl_wait && guard < 64) begin
      tick();
      guard++;
    end
    if (guard >= 64) checkOutput("waitBound", guard, 0);
  endtask

  // Push one byte respecting ioctl_wait and check the resulting write.
  task automatic applyStimulus(input logic [24:0] a, input logic [7:0] d);
    waitReady();
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    expWe = modelRegion(a);
    tick();
    bus.ioctl_wr = 1'b0;
    if (expWe != 3'b000) begin
      checkOutput("romAddr", {15'd0, bus.rom_addr}, {15'd0, modelRel(a)});
      checkOutput("romData", {24'd0, bus.rom_data}, {24'd0, d});
      modelBytes++;
    end else begin
      modelErr = 1'b1;
    end
    expWe = 3'b000;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic streamRange(input int lo, input int hi);
    for (int a = lo; a < hi; a++) applyStimulus(25'(a), 8'($urandom));
  endtask

  task automatic beginDownload();
    bus.ioctl_index    = 8'd1;
    bus.ioctl_download = 1'b1;
    modelBytes = 0;
    modelErr   = 1'b0;
    mainSeen   = 0;
    gfxSeen    = 0;
    sndSeen    = 0;
  endtask

  // Drop the download between slots, check the verdict and the reset hold.
  task automatic endDownload(input string tag);
    int  n = 0;
    bit  expReady;
    waitReady();
    bus.ioctl_download = 1'b0;
    tick();
    expReady = (modelBytes == int'(SND_END)) && !modelErr;
    checkOutput({tag, "Ready"}, {31'd0, bus.rom_ready}, {31'd0, expReady});
    checkOutput({tag, "Error"}, {31'd0, bus.load_error}, {31'd0, !expReady});
    while (bus.board_reset && n < HOLD_CYCLES + 64) begin
      n++;
      tick();
    end
    if (expReady) checkOutput({tag, "HoldLen"}, n, HOLD_CYCLES);
    else          checkOutput({tag, "ResetStuck"}, {31'd0, bus.board_reset}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hi;
    int n;
    reset              = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.ioctl_index    = 8'd1;
    mainSeen = 0; gfxSeen = 0; sndSeen = 0;

    // Reset state.
    repeat (3) tick();
    checkOutput("rstWait", {31'd0, bus.ioctl_wait}, 32'd0);
    checkOutput("rstAddr", {15'd0, bus.rom_addr}, 32'd0);
    checkOutput("rstData", {24'd0, bus.rom_data}, 32'd0);
    checkOutput("rstBoard", {31'd0, bus.board_reset}, 32'd1);
    checkOutput("rstReady", {31'd0, bus.rom_ready}, 32'd0);
    checkOutput("rstError", {31'd0, bus.load_error}, 32'd0);
    reset = 1'b0;
    tick();

    // Full image, first byte together with the download's rising edge.
    $display("[TB] full image");
    beginDownload();
    streamRange(0, int'(SND_END));
    checkOutput("fullMain", mainSeen, int'(MAIN_END));
    checkOutput("fullGfx", gfxSeen, int'(GFX_END - MAIN_END));
    checkOutput("fullSnd", sndSeen, int'(SND_END - GFX_END));
    endDownload("full");

    // Reset pulse in RUN keeps the image and re-runs the hold period.
    $display("[TB] reset in RUN");
    reset = 1'b1;
    repeat (3) begin
      tick();
      checkOutput("runRstBoard", {31'd0, bus.board_reset}, 32'd1);
    end
    reset = 1'b0;
    n = 0;
    while (bus.board_reset && n < HOLD_CYCLES + 64) begin
      n++;
      tick();
    end
    checkOutput("runRstHold", n, HOLD_CYCLES);
    checkOutput("runRstReady", {31'd0, bus.rom_ready}, 32'd1);

    // Non-ROM index download is ignored.
    $display("[TB] index filter");
    bus.ioctl_index    = 8'd0;
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = 8'($urandom);
      tick();
      bus.ioctl_wr = 1'b0;
      checkOutput("idxWait", {31'd0, bus.ioctl_wait}, 32'd0);
      tick();
    end
    bus.ioctl_download = 1'b0;
    tick();
    checkOutput("idxReady", {31'd0, bus.rom_ready}, 32'd1);
    checkOutput("idxBoard", {31'd0, bus.board_reset}, 32'd0);

    // Handshake timing and a byte pushed during the stall.
    $display("[TB] handshake");
    beginDownload();
    tick();
    checkOutput("hsReadyClr", {31'd0, bus.rom_ready}, 32'd0);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'd0;
    bus.ioctl_dout = 8'hC3;
    expWe = 3'b100;
    tick();
    expWe = 3'b000;
    checkOutput("hsData", {24'd0, bus.rom_data}, 32'h0000_00C3);
    hi = bus.ioctl_wait ? 1 : 0;
    for (int k = 0; k < 8; k++) begin
      bus.ioctl_wr   = (k == 0);
      bus.ioctl_addr = 25'd1;
      tick();
      if (bus.ioctl_wait) hi++;
    end
    bus.ioctl_wr = 1'b0;
    checkOutput("hsWaitLen", hi, WR_CYCLES);
    checkOutput("hsCollideErr", {31'd0, bus.load_error}, 32'd1);
    bus.ioctl_download = 1'b0;
    tick();
    checkOutput("hsReady", {31'd0, bus.rom_ready}, 32'd0);
    checkOutput("hsError", {31'd0, bus.load_error}, 32'd1);
    repeat (HOLD_CYCLES + 8) tick();

    // Short image, download dropped in the middle of the last write slot.
    $display("[TB] short image");
    beginDownload();
    streamRange(0, int'(SND_END) - 2);
    waitReady();
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = SND_END - 25'd2;
    bus.ioctl_dout = 8'h11;
    expWe = 3'b001;
    tick();
    expWe = 3'b000;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    repeat (WR_CYCLES + 1) tick();
    checkOutput("shortWait", {31'd0, bus.ioctl_wait}, 32'd0);
    checkOutput("shortReady", {31'd0, bus.rom_ready}, 32'd0);
    checkOutput("shortError", {31'd0, bus.load_error}, 32'd1);
    repeat (HOLD_CYCLES + 16) tick();
    checkOutput("shortBoard", {31'd0, bus.board_reset}, 32'd1);

    // Full image with an out-of-range byte in the middle.
    $display("[TB] out-of-range byte");
    beginDownload();
    streamRange(0, 'h100);
    applyStimulus(SND_END, 8'h5A);
    streamRange('h100, int'(SND_END));
    checkOutput("oorSnd", sndSeen, int'(SND_END - GFX_END));
    endDownload("oor");

    // Reset in the middle of a write slot.
    $display("[TB] reset mid-write");
    beginDownload();
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'd0;
    bus.ioctl_dout = 8'h77;
    expWe = 3'b100;
    tick();
    expWe = 3'b000;
    bus.ioctl_wr = 1'b0;
    checkOutput("mwWaitHigh", {31'd0, bus.ioctl_wait}, 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("mwWaitDrop", {31'd0, bus.ioctl_wait}, 32'd0);
    tick();
    reset = 1'b0;
    bus.ioctl_download = 1'b0;
    repeat (HOLD_CYCLES + 16) tick();
    checkOutput("mwReady", {31'd0, bus.rom_ready}, 32'd0);
    checkOutput("mwError", {31'd0, bus.load_error}, 32'd0);
    checkOutput("mwBoard", {31'd0, bus.board_reset}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/qbert_rom_loader.md
Name: qbert_rom_loader

Overview:
- Sequences the HPS ROM download stream (ioctl_*) into the core's ROM regions: main CPU program, graphics, and sound CPU.
- Owns the ioctl_wait handshake and produces per-region write strobes with region-relative addresses.
- Sequences the board reset so that mylstar_board and ma216_board stay in reset while a download is in progress and for a hold period after it ends.
- Sits in emu between hps_io and the two boards, replacing the direct ioctl fan-out.

Parameters:
- ROM_INDEX, 8'd1: ioctl_index value that marks a ROM download; other indices are ignored.
- MAIN_END, 25'h0A000: exclusive end of the main region. The main region starts at 0.
- GFX_END, 25'h12000: exclusive end of the graphics region. The graphics region starts at MAIN_END.
- SND_END, 25'h13000: exclusive end of the sound region, and the required total image size.
- WR_CYCLES, 4: clock cycles per write slot, 2..15. Covers slower target RAM ports.
- HOLD_CYCLES, 1024: number of cycles board_reset is held after download end or after reset release.

Ports:
- clk_sys, in, 1: system clock; the only clock.
- reset, in, 1: synchronous, active-high.
- ioctl_download, in, 1: download active (from hps_io).
- ioctl_wr, in, 1: single-cycle byte strobe.
- ioctl_addr, in, 25: byte address.
- ioctl_dout, in, 8: byte data.
- ioctl_index, in, 8: download index.
- ioctl_wait, out, 1: stall request to hps_io.
- rom_addr, out, 17: region-relative address.
- rom_data, out, 8: write data.
- main_we, out, 1: main region write strobe.
- gfx_we, out, 1: graphics region write strobe.
- snd_we, out, 1: sound region write strobe.
- board_reset, out, 1: reset to both boards.
- rom_ready, out, 1: a complete image is loaded.
- load_error, out, 1: sticky error from the last download.

Behaviour:
- A download is active when `ioctl_download & (ioctl_index == ROM_INDEX)`; call this `dl`. Transfers are only accepted while `dl` is high.
- States:
  - IDLE: waiting for a download.
  - LOAD: download active, waiting for a byte.
  - WRITE: issuing one write slot.
  - HOLD: holding board_reset after the download ends.
  - RUN: normal operation.
- Reset values: state = HOLD with hold counter = HOLD_CYCLES, ioctl_wait = 0, all *_we = 0, rom_addr = 0, rom_data = 0, byte counter = 0.
- rom_ready and load_error are not affected by reset. Their power-up value is 0, so an OSD reset does not invalidate loaded ROM.
- IDLE/RUN/HOLD -> LOAD on `dl` rising edge:
  - clear the byte counter, load_error and rom_ready;
  - if an ioctl_wr arrives in that same cycle, accept it as well.
- LOAD, on ioctl_wr:
  - latch address and data;
  - decode the region: addr < MAIN_END -> main; < GFX_END -> gfx; < SND_END -> snd; otherwise out of range;
  - set rom_addr = addr - region base, truncated to 17 bits;
  - set ioctl_wait = 1 in the next cycle;
  - go to WRITE.
- WRITE:
  - Cycle 0: assert exactly one *_we for one cycle. No strobe for an out-of-range byte; that byte sets load_error.
  - Hold ioctl_wait = 1 for WR_CYCLES cycles in total.
  - Increment the byte counter for in-range bytes.
  - Return to LOAD with ioctl_wait = 0.
  - rom_addr and rom_data stay stable from the strobe until the next accept.
- ioctl_wr while ioctl_wait is high: ignored (no write) and sets load_error.
- LOAD -> HOLD on `dl` falling edge:
  - rom_ready = 1 if the byte counter == SND_END and load_error == 0;
  - otherwise load_error = 1 and rom_ready = 0;
  - hold counter = HOLD_CYCLES.
- `dl` falling during WRITE: finish the slot first, then evaluate as above.
- HOLD: decrement the hold counter; at 0 go to RUN. A `dl` rising edge in HOLD goes to LOAD.
- board_reset = 1 in any state except RUN; in RUN board_reset = ~rom_ready.
- Non-ROM index downloads: ignored entirely; no state change and ioctl_wait stays 0.
- Reset asserted mid-WRITE: the strobe is aborted, ioctl_wait drops the next cycle, and the machine goes to HOLD. rom_ready keeps its prior value, which is 0, since LOAD cleared it.
- Byte counter is 25 bits and saturates at all-ones.

Test Plan:
- Full image: stream 0x13000 bytes at index 1, one ioctl_wr per slot. Required:
  - 0xA000 main_we, 0x8000 gfx_we and 0x1000 snd_we pulses;
  - byte 0x0A000 appears as gfx_we with rom_addr 0;
  - rom_ready = 1 and load_error = 0 after the falling edge;
  - board_reset falls exactly 1024 cycles later.
- Handshake: ioctl_wr at cycle t. Required: main_we at t+1, ioctl_wait high for cycles t+1..t+4 (WR_CYCLES = 4), and a second ioctl_wr at t+2 is ignored with load_error = 1.
- Short image: stream 0x12FFF bytes, then drop ioctl_download. Required: rom_ready = 0, load_error = 1, and board_reset stays 1 in RUN.
- Out-of-range byte: write addr 0x13000 with data 0x5A. Required: no strobe; the byte counter is unchanged; load_error = 1 at the end of the download.
- Reset after a good load: pulse reset for 3 cycles while in RUN. Required: rom_ready stays 1 and board_reset is high for reset plus 1024 cycles. Asserting reset mid-WRITE drops ioctl_wait the next cycle.
- Index filter: download with index 0 and 10 ioctl_wr pulses. Required: no *_we, ioctl_wait = 0, and rom_ready is unchanged.
